// File: rtl/display_scan_ctrl.sv
// Four-digit display scanner: time-multiplexes digit nibbles with dead-time and a tear-free shadow buffer.
// Optional build macro DISPLAY_SCAN_LEADING_ZERO_BLANK_EN auto-blanks leading zero digits 3..1.
module display_scan_ctrl #(
    parameter int CLK_DIV     = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        en_in,
    input  logic        load_in,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    output logic [1:0]  sel_out,
    output logic        en_n_out,
    output logic [3:0]  nibble_out,
    output logic        dp_out,
    output logic        frame_out
);

    localparam int CNT_MAX = (CLK_DIV > DEAD_CYCLES + 1) ? CLK_DIV : DEAD_CYCLES + 1;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_sel;
    logic             r_en_n;
    logic [3:0]       r_nibble;
    logic             r_dp;
    logic             r_frame;
    logic [15:0]      r_sh_data;
    logic [3:0]       r_sh_dp;
    logic [3:0]       r_sh_blank;
    logic [15:0]      r_pd_data;
    logic [3:0]       r_pd_dp;
    logic [3:0]       r_pd_blank;
    logic             r_pd_valid;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_sel_nxt;
    logic             w_adv;
    logic             w_wrap;
    logic [15:0]      w_sh_data;
    logic [3:0]       w_sh_dp;
    logic [3:0]       w_sh_blank;
    logic [15:0]      w_pd_data;
    logic [3:0]       w_pd_dp;
    logic [3:0]       w_pd_blank;
    logic             w_pd_valid;
    logic [3:0]       w_lz;
    logic             w_en_n_nxt;
    logic [3:0]       w_nibble_nxt;
    logic             w_dp_nxt;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_sel      <= 2'd0;
            r_en_n     <= 1'b1;
            r_nibble   <= 4'd0;
            r_dp       <= 1'b0;
            r_frame    <= 1'b0;
            r_sh_data  <= 16'd0;
            r_sh_dp    <= 4'd0;
            r_sh_blank <= 4'd0;
            r_pd_data  <= 16'd0;
            r_pd_dp    <= 4'd0;
            r_pd_blank <= 4'd0;
            r_pd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sel      <= w_sel_nxt;
            r_en_n     <= w_en_n_nxt;
            r_nibble   <= w_nibble_nxt;
            r_dp       <= w_dp_nxt;
            r_frame    <= w_wrap;
            r_sh_data  <= w_sh_data;
            r_sh_dp    <= w_sh_dp;
            r_sh_blank <= w_sh_blank;
            r_pd_data  <= w_pd_data;
            r_pd_dp    <= w_pd_dp;
            r_pd_blank <= w_pd_blank;
            r_pd_valid <= w_pd_valid;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_adv       = 1'b0;
        w_wrap      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_sel_nxt = 2'd0;
                if (en_in) begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!en_in) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_sel_nxt   = 2'd0;
                end else if (r_cnt == SCAN_LAST) begin
                    w_cnt_nxt = '0;
                    if (DEAD_CYCLES > 0) begin
                        w_state_nxt = S_DEAD;
                    end else begin
                        w_adv = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DEAD: begin
                if (!en_in) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_sel_nxt   = 2'd0;
                end else if (r_cnt == DEAD_LAST) begin
                    w_state_nxt = S_SCAN;
                    w_cnt_nxt   = '0;
                    w_adv       = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_sel_nxt   = 2'd0;
            end
        endcase
        if (w_adv) begin
            w_sel_nxt = r_sel + 2'd1;
            w_wrap    = (r_sel == 2'd3);
        end
    end

    // Wrap promotion happens before load capture so a load on the wrap edge waits for the next wrap.
    always_comb begin
        w_sh_data  = r_sh_data;
        w_sh_dp    = r_sh_dp;
        w_sh_blank = r_sh_blank;
        w_pd_data  = r_pd_data;
        w_pd_dp    = r_pd_dp;
        w_pd_blank = r_pd_blank;
        w_pd_valid = r_pd_valid;
        if (w_wrap && r_pd_valid) begin
            w_sh_data  = r_pd_data;
            w_sh_dp    = r_pd_dp;
            w_sh_blank = r_pd_blank;
            w_pd_valid = 1'b0;
        end
        if (load_in) begin
            if (r_state == S_IDLE) begin
                w_sh_data  = data_in;
                w_sh_dp    = dp_in;
                w_sh_blank = blank_in;
            end else begin
                w_pd_data  = data_in;
                w_pd_dp    = dp_in;
                w_pd_blank = blank_in;
                w_pd_valid = 1'b1;
            end
        end
    end

`ifdef DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
    assign w_lz[3] = (w_sh_data[15:12] == 4'd0);
    assign w_lz[2] = w_lz[3] && (w_sh_data[11:8] == 4'd0);
    assign w_lz[1] = w_lz[2] && (w_sh_data[7:4] == 4'd0);
    assign w_lz[0] = 1'b0;
`else
    assign w_lz = 4'd0;
`endif

    // Outputs are computed from next-state values so they are registered alongside the state.
    always_comb begin
        w_en_n_nxt   = 1'b1;
        w_nibble_nxt = r_nibble;
        w_dp_nxt     = r_dp;
        if (w_state_nxt == S_SCAN) begin
            w_nibble_nxt = w_sh_data[{w_sel_nxt, 2'b00} +: 4];
            w_dp_nxt     = w_sh_dp[w_sel_nxt];
            w_en_n_nxt   = w_sh_blank[w_sel_nxt] | w_lz[w_sel_nxt];
        end
    end

    assign sel_out    = r_sel;
    assign en_n_out   = r_en_n;
    assign nibble_out = r_nibble;
    assign dp_out     = r_dp;
    assign frame_out  = r_frame;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: vector table for the basic scan plus hand-written corner sequences.
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, ld_a, en_b, ld_b;
    logic [15:0] d_a, d_b;
    logic [3:0]  dp_a, bl_a, dp_b, bl_b;
    logic [1:0]  sel_a, sel_b;
    logic        en_n_a, en_n_b, dpo_a, dpo_b, fr_a, fr_b;
    logic [3:0]  nib_a, nib_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    display_scan_ctrl #(.CLK_DIV(4), .DEAD_CYCLES(1)) u_dut_a (
        .clk_in(clk), .rst_in(rst), .en_in(en_a), .load_in(ld_a), .data_in(d_a),
        .dp_in(dp_a), .blank_in(bl_a), .sel_out(sel_a), .en_n_out(en_n_a),
        .nibble_out(nib_a), .dp_out(dpo_a), .frame_out(fr_a)
    );

    display_scan_ctrl #(.CLK_DIV(4), .DEAD_CYCLES(0)) u_dut_b (
        .clk_in(clk), .rst_in(rst), .en_in(en_b), .load_in(ld_b), .data_in(d_b),
        .dp_in(dp_b), .blank_in(bl_b), .sel_out(sel_b), .en_n_out(en_n_b),
        .nibble_out(nib_b), .dp_out(dpo_b), .frame_out(fr_b)
    );

    typedef struct {
        logic        en;
        logic        ld;
        logic [15:0] d;
        logic [3:0]  dp;
        logic [3:0]  bl;
        logic [1:0]  sel;
        logic        en_n;
        logic [3:0]  nib;
        logic        dpo;
        logic        fr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic en, input logic ld, input logic [15:0] d,
                       input logic [3:0] dp, input logic [3:0] bl, input logic [1:0] sel,
                       input logic en_n, input logic [3:0] nib, input logic dpo, input logic fr);
        vec_t v;
        v.en = en; v.ld = ld; v.d = d; v.dp = dp; v.bl = bl;
        v.sel = sel; v.en_n = en_n; v.nib = nib; v.dpo = dpo; v.fr = fr;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sel_a(input logic [1:0] s);
        int n = 0;
        while (sel_a != s && n < 50) begin
            tick();
            n++;
        end
        chk("wait_sel", int'(sel_a), int'(s));
    endtask

    // One 20-cycle frame of DUT A, first tick lands on digit 0 on-time cycle 0.
    task automatic check_frame(input string tag, input logic [15:0] d, input logic [3:0] dp,
                               input logic [3:0] lit, input bit wrap_first);
        int dig;
        bit on;
        for (int k = 0; k < 20; k++) begin
            tick();
            ld_a = 1'b0;
            dig = k / 5;
            on = (k % 5) < 4;
            chk({tag, "_sel"}, int'(sel_a), dig);
            chk({tag, "_en_n"}, int'(en_n_a), int'(!(on && lit[dig])));
            chk({tag, "_nib"}, int'(nib_a), int'(d[dig*4 +: 4]));
            chk({tag, "_dp"}, int'(dpo_a), int'(dp[dig]));
            chk({tag, "_frame"}, int'(fr_a), int'(k == 0 && wrap_first));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] lz_mask1, lz_mask2;
        bit done;
        rst = 1'b1;
        en_a = 0; ld_a = 0; d_a = 0; dp_a = 0; bl_a = 0;
        en_b = 0; ld_b = 0; d_b = 0; dp_b = 0; bl_b = 0;
        #2;
        chk("rst_sel", int'(sel_a), 0);
        chk("rst_en_n", int'(en_n_a), 1);
        chk("rst_nib", int'(nib_a), 0);
        chk("rst_frame", int'(fr_a), 0);
        #10 rst = 1'b0;

        // Basic scan of 0x1234, dp on digits 0 and 2.
        add(1, 0, 1, 16'h1234, 4'b0101, 4'b0000, 2'd0, 1, 4'd0, 0, 0);
        add(4, 1, 0, 16'h0000, 4'b0000, 4'b0000, 2'd0, 0, 4'd4, 1, 0);
        add(1, 1, 0, 16'h0000, 4'b0000, 4'b0000, 2'd0, 1, 4'd4, 1, 0);
        add(4, 1, 0, 16'h0000, 4'b0000, 4'b0000, 2'd1, 0, 4'd3, 0, 0);
        add(1, 1, 0, 16'h0000, 4'b0000, 4'b0000, 2'd1, 1, 4'd3, 0, 0);
        add(4, 1, 0, 16'h0000, 4'b0000, 4'b0000, 2'd2, 0, 4'd2, 1, 0);
        add(1, 1, 0, 16'h0000, 4'b0000, 4'b0000, 2'd2, 1, 4'd2, 1, 0);
        add(4, 1, 0, 16'h0000, 4'b0000, 4'b0000, 2'd3, 0, 4'd1, 0, 0);
        add(1, 1, 0, 16'h0000, 4'b0000, 4'b0000, 2'd3, 1, 4'd1, 0, 0);
        add(1, 1, 0, 16'h0000, 4'b0000, 4'b0000, 2'd0, 0, 4'd4, 1, 1);
        add(1, 1, 0, 16'h0000, 4'b0000, 4'b0000, 2'd0, 0, 4'd4, 1, 0);
        foreach (vecs[i]) begin
            en_a = vecs[i].en; ld_a = vecs[i].ld; d_a = vecs[i].d;
            dp_a = vecs[i].dp; bl_a = vecs[i].bl;
            tick();
            chk("vec_sel", int'(sel_a), int'(vecs[i].sel));
            chk("vec_en_n", int'(en_n_a), int'(vecs[i].en_n));
            chk("vec_nib", int'(nib_a), int'(vecs[i].nib));
            chk("vec_dp", int'(dpo_a), int'(vecs[i].dpo));
            chk("vec_frame", int'(fr_a), int'(vecs[i].fr));
        end
        ld_a = 0;

        // Tear-free: loads during the frame never disturb it; last load wins.
        wait_sel_a(2'd1);
        ld_a = 1; d_a = 16'hABCD; dp_a = 4'b1111; bl_a = 4'b0000;
        tick();
        ld_a = 0;
        chk("tear_nib1", int'(nib_a), 3);
        wait_sel_a(2'd2);
        ld_a = 1; d_a = 16'h5678; dp_a = 4'b1010; bl_a = 4'b0000;
        tick();
        ld_a = 0;
        chk("tear_nib2", int'(nib_a), 2);
        done = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (sel_a == 2'd3 && en_n_a == 1'b1) begin
                done = 1;
                break;
            end
            chk("tear_old_nib", int'(nib_a), 4 - int'(sel_a));
        end
        chk("tear_reach_dead3", int'(done), 1);
        check_frame("tear_new", 16'h5678, 4'b1010, 4'b1111, 1);

        // Load on the wrap cycle is deferred a full frame; then digit 3 is blanked.
        ld_a = 1; d_a = 16'h1234; dp_a = 4'b0000; bl_a = 4'b1000;
        check_frame("wrapload", 16'h5678, 4'b1010, 4'b1111, 1);
        check_frame("blank", 16'h1234, 4'b0000, 4'b0111, 1);

        // Enable drop at on-time cycle 2 of digit 2, then restart with a full on-time.
        wait_sel_a(2'd2);
        tick();
        tick();
        en_a = 0;
        tick();
        chk("drop_en_n", int'(en_n_a), 1);
        chk("drop_sel", int'(sel_a), 0);
        tick();
        chk("idle_en_n", int'(en_n_a), 1);
        en_a = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("reen_sel", int'(sel_a), 0);
            chk("reen_en_n", int'(en_n_a), 0);
            chk("reen_nib", int'(nib_a), 4);
            chk("reen_frame", int'(fr_a), 0);
        end
        tick();
        chk("reen_dead", int'(en_n_a), 1);
        chk("reen_dead_sel", int'(sel_a), 0);

        // Asynchronous reset mid-scan.
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_sel", int'(sel_a), 0);
        chk("arst_en_n", int'(en_n_a), 1);
        chk("arst_nib", int'(nib_a), 0);
        chk("arst_dp", int'(dpo_a), 0);
        chk("arst_frame", int'(fr_a), 0);
        en_a = 0;
        @(negedge clk);
        rst = 1'b0;

`ifdef DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
        lz_mask1 = 4'b0011;
        lz_mask2 = 4'b0001;
`else
        lz_mask1 = 4'b1111;
        lz_mask2 = 4'b1111;
`endif
        ld_a = 1; d_a = 16'h0045; dp_a = 4'b0000; bl_a = 4'b0000;
        tick();
        ld_a = 0; en_a = 1;
        check_frame("lz45", 16'h0045, 4'b0000, lz_mask1, 0);
        en_a = 0;
        tick();
        ld_a = 1; d_a = 16'h0000;
        tick();
        ld_a = 0; en_a = 1;
        check_frame("lz00", 16'h0000, 4'b0000, lz_mask2, 0);
        en_a = 0;

        // No dead-time: lit continuously, 16-cycle frame.
        ld_b = 1; d_b = 16'h1234; dp_b = 4'b0000; bl_b = 4'b0000;
        tick();
        ld_b = 0; en_b = 1;
        for (int k = 0; k < 32; k++) begin
            tick();
            chk("nodead_sel", int'(sel_b), (k / 4) % 4);
            chk("nodead_en_n", int'(en_n_b), 0);
            chk("nodead_nib", int'(nib_b), 4 - ((k / 4) % 4));
            chk("nodead_frame", int'(fr_b), int'(k == 16));
        end
        en_b = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Upstream driver for the 2-to-4 one-hot digit decoder in the 4-digit display path.
- Time-multiplexes four 4-bit digit values and generates the decoder's 2-bit select and active-low enable.
- Inserts dead-time between digits to prevent ghosting.
- Double-buffers display data so a frame never tears.

Parameters:
- CLK_DIV, 50000, clk_in cycles each digit is driven (on-time); legal range >= 2.
- DEAD_CYCLES, 2, clk_in cycles with decoder disabled between digits; 0 means no dead-time.

Ports:
- clk_in  input  1  system clock, rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- en_in  input  1  scan enable; 0 forces idle.
- load_in  input  1  single-cycle strobe that captures data_in/dp_in/blank_in.
- data_in  input  16  four nibbles; [3:0] is digit 0, [15:12] is digit 3.
- dp_in  input  4  decimal point per digit.
- blank_in  input  4  per-digit blank mask; 1 means digit is dark.
- sel_out  output  2  digit index, to the decoder select.
- en_n_out  output  1  active-low decoder enable; 0 means the digit is lit.
- nibble_out  output  4  value of the current digit, to the segment encoder.
- dp_out  output  1  decimal point of the current digit.
- frame_out  output  1  one-cycle pulse at each frame wrap.

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_in is asynchronous and active-high.
- Registered outputs: all outputs are registered.
- Reset values:
  - sel_out=0, en_n_out=1, nibble_out=0, dp_out=0, frame_out=0.
  - Shadow registers and pending registers = 0; pending_valid=0.
  - Counter=0; state=IDLE.
- Counter width: $clog2(max(CLK_DIV, DEAD_CYCLES+1)). The counter saturates at no point; it is cleared on every state change.
- State IDLE:
  - Outputs: en_n_out=1, sel_out=0, counter held at 0.
  - load_in in IDLE writes the shadow registers directly on the next edge.
  - If en_in=1, go to SCAN with digit 0 on the next edge.
- State SCAN:
  - sel_out = current digit; nibble_out/dp_out come from the shadow registers for that digit.
  - en_n_out = shadow blank bit of that digit.
  - Stays in SCAN for exactly CLK_DIV cycles.
  - At count CLK_DIV-1: go to DEAD if DEAD_CYCLES>0; otherwise advance the digit and stay in SCAN.
- State DEAD:
  - Outputs: en_n_out=1; sel_out and nibble_out hold their values.
  - Lasts DEAD_CYCLES cycles, then advance the digit and return to SCAN.
- Digit advance: sel increments modulo 4.
- Frame wrap (3 to 0), in the same edge:
  - frame_out=1 for one cycle.
  - If pending_valid, shadow <= pending and pending_valid is cleared.
- Frame period: 4*(CLK_DIV+DEAD_CYCLES) cycles.
- load_in outside IDLE:
  - Captures into the pending registers and sets pending_valid.
  - A later load before the wrap overwrites the earlier one (last wins).
  - A load in the same cycle as the wrap lands in pending and is applied at the following wrap.
- en_in deasserted in SCAN or DEAD: next edge goes to IDLE (en_n_out=1, sel_out=0). pending_valid is retained.
- Re-enable: scanning always restarts at digit 0 with a full on-time.
- rst_in mid-scan: all registers return to their reset values immediately, with no clock needed.

Optional Feature:
- Macro: DISPLAY_SCAN_LEADING_ZERO_BLANK_EN.
- When defined, digits 3..1 are additionally blanked (en_n_out=1 during their SCAN slot) while they and every more-significant digit hold nibble 0. Digit 0 is never auto-blanked. The result is OR'd with the blank mask.
- When undefined, only blank_in controls blanking.

Test Plan (CLK_DIV=4, DEAD_CYCLES=1 unless stated):
1. Reset:
   - Stimulus: assert rst_in asynchronously between clock edges.
   - Response: sel_out=0, en_n_out=1, nibble_out=0, frame_out=0 immediately.
2. Basic scan:
   - Stimulus: in IDLE, load 0x1234, blank_in=0, then en_in=1.
   - Response: per digit, 4 cycles of en_n_out=0 followed by 1 cycle of en_n_out=1. nibble_out sequence is 4,3,2,1 at sel 0,1,2,3. frame_out pulses every 20 cycles as sel goes 3 to 0.
3. Tear-free load:
   - Stimulus: while sel=1, load 0xABCD; then load 0x5678 while sel=2.
   - Response: rest of the frame shows 3,2,1. After frame_out the display shows 8,7,6,5; 0xABCD never appears.
4. Blanking:
   - Stimulus: blank_in=4'b1000 loaded.
   - Response: en_n_out=1 for all 4 SCAN cycles of sel=3; other digits are lit.
5. Enable drop and no-dead-time case:
   - Stimulus: en_in=0 at cycle 2 of digit 2.
   - Response: next cycle en_n_out=1 and sel_out=0. On re-enable, digit 0 is driven for a full 4 cycles.
   - With DEAD_CYCLES=0: en_n_out stays 0 continuously and the frame is 16 cycles.
6. Optional feature:
   - Stimulus: macro defined, data 0x0045.
   - Response: digits 3 and 2 are dark; digits 1 and 0 show 4 and 5.
   - Stimulus: data 0x0000.
   - Response: only digit 0 is lit, showing 0.
